// File: rtl/debounce_pkg.sv
// Shared types for the input debouncer: FSM state encoding and counter sizing helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } deb_state_e;

    // Counter must hold 0..DEBOUNCE_CYCLES-1 with headroom; never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous level; all stages clear to 0 on reset.
// Reusable in front of any edge detector that needs a clean synchronous level.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Bit 0 is the capture stage, the MSB feeds downstream logic.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronise din_raw and accept a new level only after DEBOUNCE_CYCLES matching samples.
// Optional rejected-glitch counter enabled by INPUT_DEBOUNCER_GLITCH_COUNT_EN; otherwise glitch_cnt is 0.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                din_raw,
    output logic                dout,
    output logic                pending,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       s;
    deb_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       dout_q, dout_d;
    logic       pending_q, pending_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (din_raw),
        .q      (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HI;
                    end else begin
                        state_d = PEND_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LO;
                    end else begin
                        state_d = PEND_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        // Outputs decoded from the next state so they leave a flop, glitch-free.
        dout_d    = (state_d == STABLE_HI) || (state_d == PEND_LO);
        pending_d = (state_d == PEND_HI) || (state_d == PEND_LO);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            dout_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            pending_q <= pending_d;
        end
    end

    assign dout    = dout_q;
    assign pending = pending_q;

`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
    logic                glitch_ev;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    // A glitch is a pending candidate falling back to the level it started from.
    always_comb begin
        glitch_ev = ((state_q == PEND_HI) && (state_d == STABLE_LO)) ||
                    ((state_q == PEND_LO) && (state_d == STABLE_HI));
        glitch_d  = glitch_q;
        if (glitch_ev && (glitch_q != '1)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = '0;
`endif

endmodule
